mdu_sequencer: RTL and testbench

- Iterative multiply/divide sequencer for the shared multi-cycle MDU used by the R-type `mul` (opcode 0, funct 0100) and `div` (opcode 0, funct 1000) instructions.
- Sits beside the decode/execute boundary and takes the same opcode/functcode fields the path control decodes.
- Runs unsigned shift-add multiply or restoring divide over WIDTH cycles and stalls the pipeline until the result is ready.
- Also latches the `halt` opcode so no new MDU work is accepted afterwards.

---
 rtl/mdu_sequencer.sv | 156 +++++++++++++++
 tb/tb_mdu_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// Iterative unsigned multiply / restoring divide for the R-type mul/div instructions.
// Latency: result_valid in cycle WIDTH+1 after accept (cycle 1 for divide-by-zero).
// Backpressure: stall holds decode from the accept cycle through the last iteration.
module mdu_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic [3:0]       opcode,
    input  logic [3:0]       functcode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero,
    output logic             halted
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    localparam logic [3:0]       OP_RTYPE = 4'h0;
    localparam logic [3:0]       OP_HALT  = 4'hF;
    localparam logic [3:0]       FN_MUL   = 4'b0100;
    localparam logic [3:0]       FN_DIV   = 4'b1000;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [CNT_W-1:0]   counter;
    // acc_hi: partial product high half (mul) or partial remainder (div)
    // acc_lo: multiplier shifting out / product low half (mul), dividend shifting into quotient (div)
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   opnd;

    logic               mul_req;
    logic               div_req;
    logic               accept;
    logic               last_iter;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_nxt;
    logic [WIDTH-1:0]   mul_lo_nxt;
    logic [WIDTH:0]     div_r;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [WIDTH-1:0]   div_hi_nxt;
    logic [WIDTH-1:0]   div_lo_nxt;

    assign mul_req   = (opcode == OP_RTYPE) && (functcode == FN_MUL);
    assign div_req   = (opcode == OP_RTYPE) && (functcode == FN_DIV);
    assign accept    = (state == S_IDLE) && issue_valid && !flush && !halted && (mul_req || div_req);
    assign last_iter = (counter == CNT_LAST);

    assign busy         = (state == S_MUL) || (state == S_DIV);
    assign result_valid = (state == S_DONE);
    assign stall        = accept || busy;

    always_comb begin
        mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        mul_hi_nxt = mul_sum[WIDTH:1];
        mul_lo_nxt = {mul_sum[0], acc_lo[WIDTH-1:1]};

        // Remainder stays below the divisor, so the restored difference fits in WIDTH bits.
        div_r      = {acc_hi, acc_lo[WIDTH-1]};
        div_ge     = (div_r >= {1'b0, opnd});
        div_diff   = div_r[WIDTH-1:0] - opnd;
        div_hi_nxt = div_ge ? div_diff : div_r[WIDTH-1:0];
        div_lo_nxt = {acc_lo[WIDTH-2:0], div_ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            counter     <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            opnd        <= '0;
            result_lo   <= '0;
            result_hi   <= '0;
            div_by_zero <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    div_by_zero <= 1'b0;
                    if (issue_valid && (opcode == OP_HALT)) begin
                        halted <= 1'b1;
                    end
                    if (accept) begin
                        counter <= '0;
                        acc_hi  <= '0;
                        if (mul_req) begin
                            state  <= S_MUL;
                            opnd   <= op_a;
                            acc_lo <= op_b;
                        end else if (op_b == '0) begin
                            state       <= S_DONE;
                            result_lo   <= '1;
                            result_hi   <= op_a;
                            div_by_zero <= 1'b1;
                        end else begin
                            state  <= S_DIV;
                            opnd   <= op_b;
                            acc_lo <= op_a;
                        end
                    end
                end
                S_MUL: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc_hi  <= mul_hi_nxt;
                        acc_lo  <= mul_lo_nxt;
                        counter <= counter + 1'b1;
                        if (last_iter) begin
                            state     <= S_DONE;
                            result_hi <= mul_hi_nxt;
                            result_lo <= mul_lo_nxt;
                        end
                    end
                end
                S_DIV: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc_hi  <= div_hi_nxt;
                        acc_lo  <= div_lo_nxt;
                        counter <= counter + 1'b1;
                        if (last_iter) begin
                            state     <= S_DONE;
                            result_hi <= div_hi_nxt;
                            result_lo <= div_lo_nxt;
                        end
                    end
                end
                S_DONE: begin
                    state       <= S_IDLE;
                    div_by_zero <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: latency, results, div-by-zero, flush, halt and reset.
module tb_mdu_sequencer;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             issue_valid;
    logic [3:0]       opcode;
    logic [3:0]       functcode;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;
    logic             stall;
    logic             busy;
    logic             result_valid;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             div_by_zero;
    logic             halted;

    int tests;
    int fails;

    mdu_sequencer #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .opcode       (opcode),
        .functcode    (functcode),
        .op_a         (op_a),
        .op_b         (op_b),
        .flush        (flush),
        .stall        (stall),
        .busy         (busy),
        .result_valid (result_valid),
        .result_lo    (result_lo),
        .result_hi    (result_hi),
        .div_by_zero  (div_by_zero),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are checked 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one op in the current cycle (cycle 0), checks stall through the
    // iterations, the result in cycle lat, then returns 2ns into cycle lat+1.
    task automatic run_op(input string name, input logic [3:0] fn,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_lo, input logic [15:0] exp_hi,
                          input logic exp_dbz, input int lat);
        opcode = 4'h0; functcode = fn; op_a = a; op_b = b; issue_valid = 1'b1;
        #1;
        check({name, "_stall_c0"}, 32'(stall), 32'd1);
        step();
        issue_valid = 1'b0; op_a = ~a; op_b = ~b;
        for (int c = 1; c < lat; c++) begin
            #1;
            check($sformatf("%s_stall_c%0d", name, c), 32'(stall), 32'd1);
            check($sformatf("%s_rv_c%0d", name, c), 32'(result_valid), 32'd0);
            step();
        end
        #1;
        check({name, "_rv"}, 32'(result_valid), 32'd1);
        check({name, "_stall_done"}, 32'(stall), 32'd0);
        check({name, "_busy_done"}, 32'(busy), 32'd0);
        check({name, "_lo"}, 32'(result_lo), 32'(exp_lo));
        check({name, "_hi"}, 32'(result_hi), 32'(exp_hi));
        check({name, "_dbz"}, 32'(div_by_zero), 32'(exp_dbz));
        step();
        #1;
        check({name, "_rv_after"}, 32'(result_valid), 32'd0);
        check({name, "_dbz_after"}, 32'(div_by_zero), 32'd0);
        check({name, "_lo_hold"}, 32'(result_lo), 32'(exp_lo));
    endtask

    initial begin
        logic rv_seen;
        tests = 0;
        fails = 0;
        rst_n = 1'b0; issue_valid = 1'b0; opcode = 4'h0; functcode = 4'h0;
        op_a = 16'h0; op_b = 16'h0; flush = 1'b0;

        // Reset state
        #12;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rv", 32'(result_valid), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_lo", 32'(result_lo), 32'd0);
        check("rst_hi", 32'(result_hi), 32'd0);
        rst_n = 1'b1;
        step();

        // Multiplies, then a divide the cycle after DONE
        run_op("mul1", 4'b0100, 16'h1234, 16'h0056, 16'h1D78, 16'h0006, 1'b0, 17);
        run_op("mulmax", 4'b0100, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 17);
        run_op("div1", 4'b1000, 16'h03E8, 16'h0007, 16'h008E, 16'h0006, 1'b0, 17);
        run_op("dbz", 4'b1000, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1);

        // Flush during a multiply in cycle 5
        opcode = 4'h0; functcode = 4'b0100; op_a = 16'h0003; op_b = 16'h0005; issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        for (int c = 1; c < 5; c++) step();
        flush = 1'b1;
        #1;
        check("flush_busy_c5", 32'(busy), 32'd1);
        step();
        flush = 1'b0;
        #1;
        check("flush_stall_c6", 32'(stall), 32'd0);
        check("flush_busy_c6", 32'(busy), 32'd0);
        rv_seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (result_valid) rv_seen = 1'b1;
            step();
        end
        check("flush_no_rv", 32'(rv_seen), 32'd0);
        check("flush_lo_hold", 32'(result_lo), 32'hFFFF);
        check("flush_hi_hold", 32'(result_hi), 32'h1234);

        // Flush in the accept cycle blocks the accept
        opcode = 4'h0; functcode = 4'b1000; op_a = 16'h0064; op_b = 16'h0003;
        issue_valid = 1'b1; flush = 1'b1;
        #1;
        check("flush_acc_stall", 32'(stall), 32'd0);
        step();
        issue_valid = 1'b0; flush = 1'b0;
        #1;
        check("flush_acc_busy", 32'(busy), 32'd0);

        // Halt blocks later work; reset clears it
        opcode = 4'hF; functcode = 4'h0; issue_valid = 1'b1;
        step();
        opcode = 4'h0; functcode = 4'b0100; op_a = 16'h0007; op_b = 16'h0009;
        #1;
        check("halt_set", 32'(halted), 32'd1);
        check("halt_mul_stall", 32'(stall), 32'd0);
        step();
        issue_valid = 1'b0;
        #1;
        check("halt_mul_busy", 32'(busy), 32'd0);
        rst_n = 1'b0;
        #1;
        check("halt_cleared", 32'(halted), 32'd0);
        rst_n = 1'b1;
        step();
        run_op("mul_after_halt", 4'b0100, 16'h0007, 16'h0009, 16'h003F, 16'h0000, 1'b0, 17);

        // Reset in cycle 8 of a divide
        opcode = 4'h0; functcode = 4'b1000; op_a = 16'h03E8; op_b = 16'h0007; issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        for (int c = 1; c < 8; c++) step();
        #1;
        check("rstdiv_busy_c8", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstdiv_busy", 32'(busy), 32'd0);
        check("rstdiv_stall", 32'(stall), 32'd0);
        check("rstdiv_lo", 32'(result_lo), 32'd0);
        check("rstdiv_hi", 32'(result_hi), 32'd0);
        rst_n = 1'b1;
        rv_seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (result_valid) rv_seen = 1'b1;
        end
        check("rstdiv_no_rv", 32'(rv_seen), 32'd0);

        // Non-MDU instructions never stall
        issue_valid = 1'b1; op_a = 16'h1111; op_b = 16'h2222;
        opcode = 4'hC; functcode = 4'b0100; #1;
        check("andi_stall", 32'(stall), 32'd0);
        step();
        opcode = 4'hB; functcode = 4'b1000; #1;
        check("sw_stall", 32'(stall), 32'd0);
        check("sw_busy", 32'(busy), 32'd0);
        step();
        opcode = 4'h4; functcode = 4'b0100; #1;
        check("beq_stall", 32'(stall), 32'd0);
        step();
        opcode = 4'h0; functcode = 4'b0000; #1;
        check("add_stall", 32'(stall), 32'd0);
        step();
        issue_valid = 1'b0;
        #1;
        check("other_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
